// File: rtl/mmio_fifo_bank_pkg.sv
// mmio_fifo_bank_pkg: CCI-P MMIO types, register map and channel decode for the FIFO bank AFU.
`ifndef AFU_ACCEL_UUID
`define AFU_ACCEL_UUID 128'h0
`endif
package mmio_fifo_bank_pkg;
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd0;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;
  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;
  typedef struct packed {
    logic [27:0]  hdr;
    logic [511:0] data;
    logic         rspValid;
    logic         mmioRdValid;
    logic         mmioWrValid;
  } t_if_ccip_c0_Rx;
  typedef struct packed {
    t_if_ccip_c0_Rx c0;
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
  } t_if_ccip_Rx;
  typedef struct packed {
    logic [73:0] hdr;
    logic        valid;
  } t_if_ccip_c0_Tx;
  typedef struct packed {
    logic [79:0]  hdr;
    logic [511:0] data;
    logic         valid;
  } t_if_ccip_c1_Tx;
  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;
  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;
  localparam logic [15:0] DFH       = 16'h0000;
  localparam logic [15:0] ID_L      = 16'h0002;
  localparam logic [15:0] ID_H      = 16'h0004;
  localparam logic [15:0] CTRL      = 16'h0010;
  localparam logic [15:0] INFO      = 16'h0012;
  localparam logic [15:0] DATA_BASE = 16'h0020;
  localparam logic [15:0] STAT_BASE = 16'h0022;
  localparam int          CH_STRIDE = 4;
  // AFU feature type in [63:60], end-of-list in [40]
  localparam logic [63:0] DFH_VAL   = 64'h1000_0100_0000_0000;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_UDF   = 3;
  localparam int ST_CNT   = 16;
  typedef struct packed {
    logic       hit;
    logic       stat;
    logic [2:0] ch;
  } t_ch_dec;
  function automatic t_ch_dec ch_decode(input logic [15:0] addr, input int num_ch);
    logic [15:0] off;
    logic [15:0] sub;
    t_ch_dec d;
    off = addr - DATA_BASE;
    sub = off % 16'(CH_STRIDE);
    d.stat = sub == (STAT_BASE - DATA_BASE);
    d.hit = addr >= DATA_BASE && (sub == '0 || d.stat) && int'(off / 16'(CH_STRIDE)) < num_ch;
    d.ch = 3'(off / 16'(CH_STRIDE));
    return d;
  endfunction
endpackage

// File: rtl/mmio_sync_fifo.sv
// mmio_sync_fifo: single-clock FIFO with flush and sticky overflow/underflow flags.
module mmio_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr_en, rd_en;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign wr_en = push & ~full & ~flush;
  assign rd_en = pop & ~empty & ~flush;
  // empty pops read back zero rather than stale storage
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
      overflow <= overflow | (push & full);
      underflow <= underflow | (pop & empty);
    end
endmodule

// File: rtl/mmio_fifo_bank_afu.sv
// mmio_fifo_bank_afu: CCI-P MMIO AFU exposing NUM_CH host-visible FIFOs
// (write pushes, read pops) plus DFH/ID/INFO/CTRL/STAT registers.
module mmio_fifo_bank_afu
  import mmio_fifo_bank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  parameter logic [127:0] AFU_ID = `AFU_ACCEL_UUID
) (
  input  logic        clk,
  input  logic        rst,
  input  t_if_ccip_Rx rx,
  output t_if_ccip_Tx tx
);
  localparam int CW = $clog2(DEPTH + 1);
  t_ccip_c0_ReqMmioHdr hdr;
  t_ch_dec dec;
  logic rd, wr;
  logic [NUM_CH-1:0] push, pop, flush, full, empty, ovf, udf;
  logic [WIDTH-1:0] dout [NUM_CH];
  logic [CW-1:0] count [NUM_CH];
  logic [63:0] ch_data, st, rdata;
  logic rsp_valid;
  logic [8:0] rsp_tid;
  logic [63:0] rsp_data;
  logic unused_ok;
  assign hdr = t_ccip_c0_ReqMmioHdr'(rx.c0.hdr);
  assign dec = ch_decode(hdr.address, NUM_CH);
  // a colliding write is dropped so the read still gets its response
  assign rd = rx.c0.mmioRdValid;
  assign wr = rx.c0.mmioWrValid & ~rd;
  assign flush = (wr && hdr.address == CTRL) ? rx.c0.data[NUM_CH-1:0] : '0;
  assign unused_ok = ^{rx, hdr};
  always_comb begin
    push = '0;
    pop = '0;
    st = '0;
    ch_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (dec.hit && dec.ch == 3'(i)) begin
        push[i] = wr && !dec.stat;
        pop[i] = rd && !dec.stat;
        st[ST_EMPTY] = empty[i];
        st[ST_FULL] = full[i];
        st[ST_OVF] = ovf[i];
        st[ST_UDF] = udf[i];
        st[ST_CNT +: 16] = 16'(count[i]);
        ch_data = dec.stat ? st : 64'(dout[i]);
      end
  end
  always_comb
    case (hdr.address)
      DFH:     rdata = DFH_VAL;
      ID_L:    rdata = AFU_ID[63:0];
      ID_H:    rdata = AFU_ID[127:64];
      INFO:    rdata = {32'h0, 16'(DEPTH), 8'(WIDTH), 8'(NUM_CH)};
      default: rdata = dec.hit ? ch_data : '0;
    endcase
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mmio_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push[c]),
      .pop(pop[c]),
      .flush(flush[c]),
      .din(rx.c0.data[WIDTH-1:0]),
      .dout(dout[c]),
      .count(count[c]),
      .full(full[c]),
      .empty(empty[c]),
      .overflow(ovf[c]),
      .underflow(udf[c])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_tid <= '0;
      rsp_data <= '0;
    end else begin
      rsp_valid <= rd;
      rsp_tid <= rd ? hdr.tid : '0;
      rsp_data <= rd ? rdata : '0;
    end
  always_comb begin
    tx = '0;
    tx.c2.mmioRdValid = rsp_valid;
    tx.c2.hdr.tid = rsp_tid;
    tx.c2.data = rsp_data;
  end
  a_no_rd_wr_collision: assert property (@(posedge clk) disable iff (rst)
    !(rx.c0.mmioRdValid && rx.c0.mmioWrValid));
endmodule

// File: tb/tb_mmio_fifo_bank_afu.sv
// tb_mmio_fifo_bank_afu: directed MMIO sequence with hand-computed expectations.
module tb_mmio_fifo_bank_afu;
  import mmio_fifo_bank_pkg::*;
  localparam logic [127:0] ID = 128'h0123456789ABCDEF_FEDCBA9876543210;
  logic clk = 1'b0;
  logic rst = 1'b1;
  t_if_ccip_Rx rx;
  t_if_ccip_Tx tx;
  int checks = 0;
  int errors = 0;

  mmio_fifo_bank_afu #(.NUM_CH(4), .DEPTH(16), .WIDTH(64), .AFU_ID(ID)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [15:0] a, input logic [8:0] t);
    t_ccip_c0_ReqMmioHdr h;
    h = '0;
    h.address = a;
    h.tid = t;
    rx = '0;
    rx.c0.hdr = h;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    set_req(a, 9'h0);
    rx.c0.data[63:0] = d;
    rx.c0.mmioWrValid = 1'b1;
    @(negedge clk);
    rx = '0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [8:0] t, input logic [63:0] exp, input string tag);
    set_req(a, t);
    rx.c0.mmioRdValid = 1'b1;
    @(negedge clk);
    rx = '0;
    chk(64'(tx.c2.mmioRdValid), 64'd1, {tag, "_valid"});
    chk(64'(tx.c2.hdr.tid), 64'(t), {tag, "_tid"});
    chk(tx.c2.data, exp, {tag, "_data"});
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk(64'(tx.c2.mmioRdValid), 64'd0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rx = '0;
    repeat (3) @(negedge clk);
    chk(64'(tx.c2.mmioRdValid), 64'd0, "reset_valid");
    chk(tx.c2.data, 64'd0, "reset_data");
    rst = 1'b0;
    @(negedge clk);
    rd(16'h0000, 9'd1, 64'h1000_0100_0000_0000, "dfh");
    rd(16'h0002, 9'd2, 64'hFEDCBA9876543210, "id_l");
    rd(16'h0004, 9'd3, 64'h0123456789ABCDEF, "id_h");
    rd(16'h0012, 9'd4, 64'h0000_0000_0010_4004, "info");
    idle_chk("single_cycle_rsp");
    rd(16'h0006, 9'd5, 64'h0, "rsvd6");
    rd(16'h0010, 9'd6, 64'h0, "ctrl_rd");
    wr(16'h0012, 64'hFFFF);
    rd(16'h0012, 9'd7, 64'h0000_0000_0010_4004, "info_ro");
    wr(16'h0020, 64'hA1);
    wr(16'h0020, 64'hA2);
    wr(16'h0020, 64'hA3);
    rd(16'h0022, 9'd8, 64'h0003_0000, "stat0_cnt3");
    wr(16'h0028, 64'hB1);
    rd(16'h0020, 9'd9, 64'hA1, "pop_a1");
    rd(16'h0020, 9'd10, 64'hA2, "pop_a2");
    rd(16'h0020, 9'd11, 64'hA3, "pop_a3");
    rd(16'h0028, 9'd12, 64'hB1, "pop_b1");
    rd(16'h0022, 9'd13, 64'h1, "stat0_empty");
    for (int i = 1; i <= 17; i++) wr(16'h0024, 64'(i));
    rd(16'h0026, 9'd14, 64'h0010_0006, "stat1_full");
    for (int i = 1; i <= 16; i++) rd(16'h0024, 9'(20 + i), 64'(i), $sformatf("pop1_%0d", i));
    rd(16'h0026, 9'd40, 64'h5, "stat1_drained");
    wr(16'h0024, 64'h55);
    rd(16'h0026, 9'd41, 64'h0001_0004, "stat1_wrap");
    rd(16'h0024, 9'd42, 64'h55, "pop_wrap");
    rd(16'h002C, 9'd43, 64'h0, "pop3_empty");
    rd(16'h002E, 9'd44, 64'h9, "stat3_udf");
    wr(16'h0010, 64'h8);
    rd(16'h002E, 9'd45, 64'h1, "stat3_flushed");
    rd(16'h0026, 9'd46, 64'h5, "stat1_kept");
    wr(16'h0020, 64'h77);
    rd(16'h0020, 9'd50, 64'h77, "b2b_data");
    rd(16'h0022, 9'd51, 64'h1, "b2b_stat");
    rd(16'h0100, 9'd52, 64'h0, "b2b_unmapped");
    rd(16'h002E, 9'd53, 64'h1, "b2b_stat3");
    idle_chk("b2b_end");
    for (int i = 1; i <= 5; i++) wr(16'h0020, 64'(8'hC0 + i));
    rd(16'h0022, 9'd60, 64'h0005_0000, "stat0_five");
    set_req(16'h0020, 9'd61);
    rx.c0.mmioRdValid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rx = '0;
    @(negedge clk);
    chk(64'(tx.c2.mmioRdValid), 64'd0, "rst_no_rsp");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_chk("post_rst_idle");
    rd(16'h0022, 9'd62, 64'h1, "stat0_after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_fifo_bank_afu.md
# mmio_fifo_bank_afu

Parametrised CCI-P MMIO AFU exposing NUM_CH independent first-in-first-out queues to the host. MMIO writes push, MMIO reads pop, and per-channel status registers report occupancy and sticky error flags. The block replaces the single-register delay-line AFU and sits directly under the CCI-P shim as the top-level `afu`-style user logic.

## Interface
- NUM_CH, 4, number of queues (1..8)
- DEPTH, 16, entries per queue; power of two, ≥2
- WIDTH, 64, data bits per entry (1..64)
- AFU_ID, `AFU_ACCEL_UUID`, 128-bit ID returned at 0x0002/0x0004
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- rx  in  t_if_ccip_Rx  host→AFU; only c0 mmioRdValid/mmioWrValid/hdr/data used
- tx  out  t_if_ccip_Tx  AFU→host; only c2 driven, c0/c1 held zero

## Operation
- Header decode: rx.c0.hdr cast to t_ccip_c0_ReqMmioHdr; address is in 32-bit word units; every register is 64-bit at an even address.
- Address map:
  - 0x0000 DFH: type=AFU(4'b0001), end-of-list=1, all else 0.
  - 0x0002 AFU_ID[63:0]; 0x0004 AFU_ID[127:64]; 0x0006, 0x0008 read 0.
  - 0x0010 CTRL, write-only: bit c=1 flushes channel c. Reads return 0.
  - 0x0012 INFO, read-only: [7:0]=NUM_CH, [15:8]=WIDTH, [31:16]=DEPTH.
  - 0x0020+4c DATA(c): write pushes data[WIDTH-1:0]; read pops head, zero-extended to 64.
  - 0x0022+4c STAT(c), read-only, no side effect: [0] empty, [1] full, [2] overflow sticky, [3] underflow sticky, [31:16] count.
- Push when full: entry dropped, contents unchanged, overflow←1.
- Pop when empty: returns 64'h0, pointers unchanged, underflow←1.
- Flush: rd/wr pointers and count←0, both sticky flags←0; multiple bits flush multiple channels in one cycle.
- Unmapped reads return 0 with a normal response. Writes to unmapped or read-only addresses are ignored.
- mmioRdValid and mmioWrValid are never both high per CCI-P. If both are high, the read is serviced and the write is dropped. The simulation assertion flags this.
- Count width is $clog2(DEPTH+1). Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset (async): all tx fields 0, every queue empty, sticky flags 0, count 0.
- Read: tx.c2.mmioRdValid=1 for exactly one cycle, the cycle after rx.c0.mmioRdValid. tx.c2.hdr.tid equals the request tid.
- Every read gets exactly one response. Back-to-back reads give back-to-back responses.
- DATA pop returns the head as of the request cycle. The pointer advances at the same edge.
- Write: push, flush and flag updates are visible from the next cycle. A STAT read one cycle after a push already shows the new count.
- Back-to-back pushes or pops to the same channel, one per cycle, are fully supported. There are no bubbles.
- Reset asserted mid-operation discards queue contents. A pending read response is not issued.

## Structure
- Package mmio_fifo_bank_pkg holds:
  - address constants: DFH, ID_L, ID_H, CTRL, INFO, DATA_BASE, STAT_BASE, CH_STRIDE=4;
  - status bit-index localparams;
  - function ch_decode(addr) returning channel index and a hit flag.
- Sub-module mmio_sync_fifo(WIDTH, DEPTH):
  - ports: clk, rst, push, pop, flush, din → dout (head, combinational), count, full, empty, overflow, underflow;
  - instantiated NUM_CH times via generate.
- The top level holds the decode, the CTRL pulse generation and the registered c2 response.

## Test plan
- Reset, then read 0x0000, 0x0002, 0x0004, 0x0012 → DFH with type=1 and EOL=1; AFU_ID halves; INFO={DEPTH=16, WIDTH=64, NUM_CH=4}. Each response one cycle after its request with matching tid.
- Push 0xA1, 0xA2, 0xA3 to ch0 and 0xB1 to ch2, then read ch0 DATA three times and ch2 once. Expected: 0xA1, 0xA2, 0xA3, 0xB1. STAT(0) then shows empty=1 and count=0.
- Push 17 entries (values 1..17) to ch1 → STAT(1) full=1, count=16, overflow=1. Then pop 16 → values 1..16 with no 17. Wrap-around is exercised by a further push/pop of 0x55.
- Pop empty ch3 → data 0, underflow=1. Write CTRL=0b1000 → STAT(3) all flags 0, empty=1; other channels unchanged.
- Back-to-back reads on consecutive cycles mixing DATA, STAT and unmapped 0x0100 → one response per cycle, in order, with the unmapped read returning 0.
- Assert rst with ch0 holding 5 entries and a read in flight → no response issued. After reset STAT(0) reads empty=1, count=0.
